// File: rtl/sobel_window_fetch.sv
// Frame sequencer for a Sobel filter: fetches each 3x3 neighbourhood through the
// memory read handshake, hands the window to the compute core, and writes the
// core's result back through the memory write handshake.
module sobel_window_fetch #(
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned IMG_H    = 8,
  parameter int unsigned OUT_BASE = 128
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  output logic        busy,
  output logic        start_read,
  output logic [7:0]  addr_r_mc,
  input  logic [7:0]  data_r_o,
  input  logic        read_data_done,
  output logic        start_write,
  output logic [7:0]  addr_w_mc,
  output logic [7:0]  data_w,
  input  logic        write_done,
  output logic [71:0] window,
  output logic        window_valid,
  input  logic [7:0]  result,
  input  logic        result_valid,
  output logic        frame_done
);

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;
  localparam int unsigned KW   = 4;
  localparam int unsigned NPIX = 9;
  localparam int unsigned WINW = NPIX * DW;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    READ_GAP  = 3'd2,
    COMPUTE   = 3'd3,
    WRITE     = 3'd4,
    WRITE_GAP = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t          state_q, state_n;
  logic [AW-1:0]   r_q, r_n;
  logic [AW-1:0]   c_q, c_n;
  logic [KW-1:0]   k_q, k_n;
  logic [AW-1:0]   cnt_q, cnt_n;
  logic [WINW-1:0] window_n;
  logic [DW-1:0]   data_w_n;
  logic [1:0]      row_off, col_off;
  logic [AW-1:0]   rd_addr_n;
  logic [AW-1:0]   wr_addr_n;
  logic            last_centre;

  // Next-state, scan counters and captured data
  always_comb begin
    state_n     = state_q;
    r_n         = r_q;
    c_n         = c_q;
    k_n         = k_q;
    cnt_n       = cnt_q;
    window_n    = window;
    data_w_n    = data_w;
    last_centre = (r_q == AW'(IMG_H - 2)) && (c_q == AW'(IMG_W - 2));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = READ;
          r_n     = AW'(1);
          c_n     = AW'(1);
          k_n     = '0;
          cnt_n   = '0;
        end
      end
      READ: begin
        if (read_data_done) begin
          for (int i = 0; i < int'(NPIX); i++) begin
            if (k_q == KW'(i)) window_n[i*DW +: DW] = data_r_o;
          end
          state_n = READ_GAP;
        end
      end
      READ_GAP: begin
        if (k_q == KW'(NPIX - 1)) begin
          state_n = COMPUTE;
        end else begin
          k_n     = k_q + KW'(1);
          state_n = READ;
        end
      end
      COMPUTE: begin
        if (result_valid) begin
          data_w_n = result;
          state_n  = WRITE;
        end
      end
      WRITE: begin
        if (write_done) state_n = WRITE_GAP;
      end
      WRITE_GAP: begin
        cnt_n = cnt_q + AW'(1);
        if (last_centre) begin
          state_n = DONE;
        end else begin
          k_n     = '0;
          state_n = READ;
          if (c_q == AW'(IMG_W - 2)) begin
            c_n = AW'(1);
            r_n = r_q + AW'(1);
          end else begin
            c_n = c_q + AW'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Window offset of pixel k: row = k/3, column = k%3 (both relative to top-left)
  always_comb begin
    row_off = 2'd0;
    col_off = 2'd0;
    case (k_n)
      KW'(0): begin row_off = 2'd0; col_off = 2'd0; end
      KW'(1): begin row_off = 2'd0; col_off = 2'd1; end
      KW'(2): begin row_off = 2'd0; col_off = 2'd2; end
      KW'(3): begin row_off = 2'd1; col_off = 2'd0; end
      KW'(4): begin row_off = 2'd1; col_off = 2'd1; end
      KW'(5): begin row_off = 2'd1; col_off = 2'd2; end
      KW'(6): begin row_off = 2'd2; col_off = 2'd0; end
      KW'(7): begin row_off = 2'd2; col_off = 2'd1; end
      KW'(8): begin row_off = 2'd2; col_off = 2'd2; end
      default: begin row_off = 2'd0; col_off = 2'd0; end
    endcase
  end

  // Read and write addresses for the upcoming request
  always_comb begin
    rd_addr_n = AW'((32'(r_n) + 32'(row_off) - 32'd1) * 32'(IMG_W)
                    + 32'(c_n) + 32'(col_off) - 32'd1);
    wr_addr_n = AW'(32'(OUT_BASE) + 32'(cnt_n));
  end

  // State, counters and registered outputs; addresses only move when a request begins
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      r_q          <= '0;
      c_q          <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      busy         <= 1'b0;
      start_read   <= 1'b0;
      start_write  <= 1'b0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      addr_r_mc    <= '0;
      addr_w_mc    <= '0;
      data_w       <= '0;
      window       <= '0;
    end else begin
      state_q      <= state_n;
      r_q          <= r_n;
      c_q          <= c_n;
      k_q          <= k_n;
      cnt_q        <= cnt_n;
      busy         <= (state_n != IDLE);
      start_read   <= (state_n == READ);
      start_write  <= (state_n == WRITE);
      window_valid <= (state_n == COMPUTE);
      frame_done   <= (state_n == DONE);
      window       <= window_n;
      data_w       <= data_w_n;
      if (state_n == READ)  addr_r_mc <= rd_addr_n;
      if (state_n == WRITE) addr_w_mc <= wr_addr_n;
    end
  end

endmodule
